ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single on-board SRAM port between the instruction bus (ibus, read-only) and the data bus (dbus, read/write).
- Sits between the CPU-side bus decoders and the physical SRAM pins.
- Arbitrates, sequences the SRAM strobes over WAIT_CYCLES clocks, and returns read data with a stall handshake.
- Exactly one SRAM access is in flight at a time.

Parameters:
- ADDR_WIDTH, 20, SRAM word-address width; the SRAM address is taken from CPU byte-address bits [ADDR_WIDTH+1:2].
- WAIT_CYCLES, 2, number of clocks the SRAM strobes are held per access; minimum 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ibus_read  in  1  ibus read request, held until ibus_stall low
- ibus_address  in  32  ibus byte address
- ibus_data_rd  out  32  ibus read data, valid in completion cycle
- ibus_stall  out  1  ibus wait
- dbus_read  in  1  dbus read request
- dbus_write  in  1  dbus write request
- dbus_address  in  32  dbus byte address
- dbus_data_wr  in  32  dbus write data
- dbus_mask  in  4  dbus byte enables, active-high
- dbus_data_rd  out  32  dbus read data
- dbus_stall  out  1  dbus wait
- sram_addr  out  ADDR_WIDTH  SRAM word address
- sram_data_out  out  32  data driven onto the SRAM bus
- sram_data_in  in  32  data sampled from the SRAM bus
- sram_data_oe  out  1  tristate enable for sram_data_out
- sram_be_n  out  4  byte enables, active-low
- sram_ce_n  out  1  chip enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_we_n  out  1  write enable, active-low

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low.
- States and transitions:
  - States: IDLE, ACCESS, DONE.
  - IDLE to ACCESS when any request is present; otherwise stay in IDLE.
  - ACCESS to DONE after WAIT_CYCLES cycles.
  - DONE to IDLE always. DONE never starts a new access, because the requester is still asserting its completed request in that cycle.
- Grant, decided in IDLE:
  - Only one requester: that requester wins.
  - Both requesting: the policy is set by the optional feature below.
  - Grant, operation, address, mask and write data are registered on the IDLE to ACCESS edge.
  - Requesters must hold their inputs stable while stalled.
- Operation:
  - dbus_read and dbus_write both high: treated as a write.
- Stall, combinational:
  - A requester with its request high sees stall=1 in every cycle except the DONE cycle of its own granted access, where stall=0.
  - A requester with no request sees stall=0.
- Latency:
  - Request in IDLE at cycle 0 gives DONE at cycle WAIT_CYCLES+1.
  - Stall is high in cycles 0..WAIT_CYCLES.
  - A losing requester waits an additional WAIT_CYCLES+2 cycles.
- ACCESS strobes:
  - sram_ce_n=0 throughout.
  - sram_be_n is ~mask for writes and 4'b0000 for reads.
  - Read: sram_oe_n=0; sram_data_in is captured on the final ACCESS edge into the granted master's read register.
  - Write: sram_data_oe=1 for all ACCESS cycles; sram_we_n=0 for the first WAIT_CYCLES-1 ACCESS cycles and 1 on the last, giving data hold.
- IDLE/DONE strobes: ce_n, oe_n and we_n are 1, sram_data_oe=0 and sram_be_n=4'hF.
- Read data:
  - ibus_data_rd and dbus_data_rd are registered and hold their last value until the next read completes for that master.
  - dbus writes do not alter dbus_data_rd.
- Reset values:
  - state=IDLE.
  - sram_ce_n, sram_oe_n and sram_we_n = 1; sram_data_oe=0; sram_be_n=4'hF; sram_addr=0; sram_data_out=0.
  - ibus_data_rd and dbus_data_rd = 32'h0.
  - Round-robin last-grant pointer = ibus.
- Reset mid-access: all strobes deassert asynchronously; the in-flight access is abandoned.

Optional Feature:
- Macro: RAM_ARBITER_ROUND_ROBIN_EN.
- Defined: on contention, grant goes to the master not granted most recently. A 1-bit last-grant register is updated on every grant and reset to ibus, so dbus wins the first contention.
- Undefined: dbus always wins on contention, and the last-grant register is absent.

Decomposition:
- A shared package holds:
  - the state enum (IDLE, ACCESS, DONE);
  - the master-id typedef (MASTER_IBUS, MASTER_DBUS);
  - the op typedef (OP_READ, OP_WRITE);
  - the zero-word constant.
- One natural sub-module, ram_arbiter_grant: combinational winner selection from the two requests plus the optional last-grant register.

Test Plan:
- Single dbus read:
  - Stimulus: WAIT_CYCLES=2, dbus_read with address 0x0000_0010, sram_data_in=0xDEADBEEF.
  - Response: sram_addr=4, oe_n low for 2 cycles, dbus_stall high for 3 cycles, then dbus_data_rd=0xDEADBEEF with stall=0.
- Masked write:
  - Stimulus: dbus_write with mask 4'b0011 and data 0x12345678.
  - Response: sram_be_n=4'b1100, data_oe high for 2 cycles, we_n low for exactly 1 cycle then high for 1 cycle.
- Simultaneous requests:
  - Round-robin on: order is dbus, ibus, dbus, ibus across 4 back-to-back contention pairs.
  - Round-robin off: dbus is served first each time, and ibus_stall stays high for 7 cycles.
- Read and write together: dbus_read=1 and dbus_write=1 -> write strobes issued, and dbus_data_rd is unchanged.
- Reset mid-access: rst_n low during ACCESS -> ce_n, we_n and oe_n go to 1 before the next clock edge; after release, the state is IDLE and the held request is restarted.
- Idle requesters: no requests for 10 cycles -> both stalls 0 and all SRAM strobes inactive.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM states, master ids, operation kinds.
// Round-robin arbitration is enabled by defining RAM_ARBITER_ROUND_ROBIN_EN.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    MASTER_IBUS = 1'b0,
    MASTER_DBUS = 1'b1
  } master_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/ram_arbiter_grant.sv
// Combinational winner selection between ibus and dbus.
// With RAM_ARBITER_ROUND_ROBIN_EN, contention goes to the master not granted last; otherwise dbus wins.
module ram_arbiter_grant
  import ram_arbiter_pkg::*;
(
  input  logic    ibus_req_i,
  input  logic    dbus_req_i,
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  input  master_e last_grant_i,
`endif
  output master_e grant_o
);

  always_comb begin
    grant_o = MASTER_IBUS;
    if (ibus_req_i && dbus_req_i) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
      if (last_grant_i == MASTER_IBUS) grant_o = MASTER_DBUS;
      else                             grant_o = MASTER_IBUS;
`else
      grant_o = MASTER_DBUS;
`endif
    end else if (dbus_req_i) begin
      grant_o = MASTER_DBUS;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one SRAM port between ibus (read-only) and dbus (read/write), one access at a time.
// Define RAM_ARBITER_ROUND_ROBIN_EN for round-robin contention; default build gives dbus priority.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ibus_read,
  input  logic [31:0]           ibus_address,
  output logic [31:0]           ibus_data_rd,
  output logic                  ibus_stall,
  input  logic                  dbus_read,
  input  logic                  dbus_write,
  input  logic [31:0]           dbus_address,
  input  logic [31:0]           dbus_data_wr,
  input  logic [3:0]            dbus_mask,
  output logic [31:0]           dbus_data_rd,
  output logic                  dbus_stall,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_data_out,
  input  logic [31:0]           sram_data_in,
  output logic                  sram_data_oe,
  output logic [3:0]            sram_be_n,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output state_e                dbg_state_o
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  master_e               grant_q;
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            mask_q;
  logic [31:0]           ibus_rd_q;
  logic [31:0]           dbus_rd_q;
  master_e               win;
  logic                  ibus_req, dbus_req, start, last_edge;
  logic                  unused_addr_bits;

  assign ibus_req  = ibus_read;
  assign dbus_req  = dbus_read | dbus_write;
  assign start     = (state_q == ST_IDLE) && (ibus_req || dbus_req);
  assign last_edge = (state_q == ST_ACCESS) && (cnt_q == LAST_CNT);

  assign unused_addr_bits = ^{ibus_address[31:ADDR_WIDTH+2], ibus_address[1:0],
                              dbus_address[31:ADDR_WIDTH+2], dbus_address[1:0]};

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  master_e last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_q <= MASTER_IBUS;
    else if (start) last_q <= win;
  end

  ram_arbiter_grant u_grant (
    .ibus_req_i   (ibus_req),
    .dbus_req_i   (dbus_req),
    .last_grant_i (last_q),
    .grant_o      (win)
  );
`else
  ram_arbiter_grant u_grant (
    .ibus_req_i (ibus_req),
    .dbus_req_i (dbus_req),
    .grant_o    (win)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ibus_req || dbus_req) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_q == LAST_CNT) state_d = ST_DONE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request attributes are frozen at grant time so the SRAM sees a stable address/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= MASTER_IBUS;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= ZERO_WORD;
      mask_q  <= 4'h0;
    end else if (start) begin
      grant_q <= win;
      op_q    <= ((win == MASTER_DBUS) && dbus_write) ? OP_WRITE : OP_READ;
      addr_q  <= (win == MASTER_IBUS) ? ibus_address[ADDR_WIDTH+1:2]
                                      : dbus_address[ADDR_WIDTH+1:2];
      wdata_q <= dbus_data_wr;
      mask_q  <= dbus_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibus_rd_q <= ZERO_WORD;
      dbus_rd_q <= ZERO_WORD;
    end else if (last_edge && (op_q == OP_READ)) begin
      if (grant_q == MASTER_IBUS) ibus_rd_q <= sram_data_in;
      else                        dbus_rd_q <= sram_data_in;
    end
  end

  // Strobes decode from registered state, so an async reset drops them immediately.
  always_comb begin
    sram_ce_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_we_n    = 1'b1;
    sram_data_oe = 1'b0;
    sram_be_n    = 4'hF;
    if (state_q == ST_ACCESS) begin
      sram_ce_n = 1'b0;
      if (op_q == OP_WRITE) begin
        sram_be_n    = ~mask_q;
        sram_data_oe = 1'b1;
        sram_we_n    = (cnt_q == LAST_CNT);
      end else begin
        sram_be_n = 4'b0000;
        sram_oe_n = 1'b0;
      end
    end
  end

  assign ibus_stall = ibus_req & ~((state_q == ST_DONE) && (grant_q == MASTER_IBUS));
  assign dbus_stall = dbus_req & ~((state_q == ST_DONE) && (grant_q == MASTER_DBUS));

  assign sram_addr     = addr_q;
  assign sram_data_out = wdata_q;
  assign ibus_data_rd  = ibus_rd_q;
  assign dbus_data_rd  = dbus_rd_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: completions are scored against an expected queue,
// SRAM strobe activity is counted per transaction. Honours RAM_ARBITER_ROUND_ROBIN_EN.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ibus_read;
  logic [31:0] ibus_address;
  logic [31:0] ibus_data_rd;
  logic        ibus_stall;
  logic        dbus_read;
  logic        dbus_write;
  logic [31:0] dbus_address;
  logic [31:0] dbus_data_wr;
  logic [3:0]  dbus_mask;
  logic [31:0] dbus_data_rd;
  logic        dbus_stall;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_out;
  logic [31:0] sram_data_in;
  logic        sram_data_oe;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  state_e      dbg_state;

  int checks;
  int errors;
  logic [32:0] exp_q[$];

  // strobe activity counters (free-running, diffed around each access)
  int          ce_cnt, oe_cnt, we_cnt, doe_cnt, weh_cnt;
  logic [3:0]  seen_be;
  logic [19:0] seen_addr;
  logic [31:0] seen_dout;
  logic [3:0]  we_seq;

  ram_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ibus_read     (ibus_read),
    .ibus_address  (ibus_address),
    .ibus_data_rd  (ibus_data_rd),
    .ibus_stall    (ibus_stall),
    .dbus_read     (dbus_read),
    .dbus_write    (dbus_write),
    .dbus_address  (dbus_address),
    .dbus_data_wr  (dbus_data_wr),
    .dbus_mask     (dbus_mask),
    .dbus_data_rd  (dbus_data_rd),
    .dbus_stall    (dbus_stall),
    .sram_addr     (sram_addr),
    .sram_data_out (sram_data_out),
    .sram_data_in  (sram_data_in),
    .sram_data_oe  (sram_data_oe),
    .sram_be_n     (sram_be_n),
    .sram_ce_n     (sram_ce_n),
    .sram_oe_n     (sram_oe_n),
    .sram_we_n     (sram_we_n),
    .dbg_state_o   (dbg_state)
  );

  // SRAM read data: word 4 holds DEADBEEF, every other word reads 5A0 followed by its address
  assign sram_data_in = (sram_addr == 20'h4) ? 32'hDEAD_BEEF : {12'h5A0, sram_addr};

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input logic m, input logic [31:0] d);
    logic [32:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: master=%0d data=%h with empty queue", m, d);
    end else begin
      e = exp_q.pop_front();
      if ({m, d} !== e) begin
        errors++;
        $display("FAIL sb_completion: got master=%0d data=%h expected master=%0d data=%h",
                 m, d, e[32], e[31:0]);
      end
    end
  endtask

  task automatic sb_monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ibus_read && !ibus_stall) sb_pop(1'b0, ibus_data_rd);
        if ((dbus_read || dbus_write) && !dbus_stall) sb_pop(1'b1, dbus_data_rd);
      end
    end
  endtask

  task automatic strobe_monitor();
    forever begin
      @(negedge clk);
      if (!sram_ce_n) begin
        ce_cnt++;
        seen_be   = sram_be_n;
        seen_addr = sram_addr;
        seen_dout = sram_data_out;
      end
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (sram_data_oe) begin
        doe_cnt++;
        if (sram_we_n) weh_cnt++;
        we_seq = {we_seq[2:0], sram_we_n};
      end
    end
  endtask

  // ---------------- drivers (caller is aligned to posedge+1) ----------------
  task automatic dbus_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] mask,
                             output int stalls);
    bit done;
    dbus_read    = rd;
    dbus_write   = wr;
    dbus_address = addr;
    dbus_data_wr = wdata;
    dbus_mask    = mask;
    stalls = 0;
    done   = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (dbus_stall) stalls++;
      else            done = 1;
    end
    if (!done) check("dbus_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    dbus_read  = 1'b0;
    dbus_write = 1'b0;
  endtask

  task automatic ibus_access(input logic [31:0] addr, output int stalls);
    bit done;
    ibus_read    = 1'b1;
    ibus_address = addr;
    stalls = 0;
    done   = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (ibus_stall) stalls++;
      else            done = 1;
    end
    if (!done) check("ibus_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    ibus_read = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ds, is, ds2, is2;
    int ce0, oe0, we0, doe0, weh0;

    checks = 0; errors = 0;
    ce_cnt = 0; oe_cnt = 0; we_cnt = 0; doe_cnt = 0; weh_cnt = 0;
    seen_be = 4'h0; seen_addr = '0; seen_dout = '0; we_seq = 4'h0;
    rst_n = 1'b0;
    ibus_read = 1'b0; ibus_address = '0;
    dbus_read = 1'b0; dbus_write = 1'b0; dbus_address = '0;
    dbus_data_wr = '0; dbus_mask = 4'h0;

    fork
      sb_monitor();
      strobe_monitor();
    join_none

    // reset values
    #2;
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, sram_be_n}, {4'b1110, 4'hF});
    check("rst_addr_dout", {sram_addr, sram_data_out}, 52'h0);
    check("rst_rdata", {ibus_data_rd, dbus_data_rd}, 64'h0);
    check("rst_state", dbg_state, ST_IDLE);
    apply_reset();

    // idle requesters
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", {ibus_stall, dbus_stall, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, sram_be_n},
            {6'b001110, 4'hF});
    end
    @(posedge clk); #1;

    // single dbus read
    ce0 = ce_cnt; oe0 = oe_cnt; we0 = we_cnt;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    dbus_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, ds);
    check("rd_stalls", ds, 3);
    check("rd_oe_cycles", oe_cnt - oe0, 2);
    check("rd_ce_cycles", ce_cnt - ce0, 2);
    check("rd_we_cycles", we_cnt - we0, 0);
    check("rd_addr_be", {seen_addr, seen_be}, {20'h4, 4'h0});

    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;

    // masked write
    oe0 = oe_cnt; we0 = we_cnt; doe0 = doe_cnt; weh0 = weh_cnt;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    dbus_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011, ds);
    check("wr_stalls", ds, 3);
    check("wr_be", seen_be, 4'b1100);
    check("wr_addr_dout", {seen_addr, seen_dout}, {20'h8, 32'h1234_5678});
    check("wr_doe_cycles", doe_cnt - doe0, 2);
    check("wr_we_low", we_cnt - we0, 1);
    check("wr_we_high", weh_cnt - weh0, 1);
    check("wr_we_order", we_seq[1:0], 2'b01);
    check("wr_oe_cycles", oe_cnt - oe0, 0);

    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;

    // read and write together behaves as a write
    oe0 = oe_cnt; we0 = we_cnt;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    dbus_access(1'b1, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'hF, ds);
    check("rw_be", seen_be, 4'b0000);
    check("rw_dout", seen_dout, 32'hCAFE_F00D);
    check("rw_we_low", we_cnt - we0, 1);
    check("rw_oe_cycles", oe_cnt - oe0, 0);

    // contention, single pair: dbus wins first in both modes
    apply_reset();
    exp_q.push_back({1'b1, 32'h5A00_0100});
    exp_q.push_back({1'b0, 32'h5A00_00C0});
    fork
      dbus_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'h0, ds);
      ibus_access(32'h0000_0300, is);
    join
    check("pair_dbus_stalls", ds, 3);
    check("pair_ibus_stalls", is, 7);

    // contention, back-to-back streams of two reads per master
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    exp_q.push_back({1'b1, 32'h5A00_0080});
    exp_q.push_back({1'b0, 32'h5A00_0040});
    exp_q.push_back({1'b1, 32'h5A00_0081});
    exp_q.push_back({1'b0, 32'h5A00_0041});
`else
    exp_q.push_back({1'b1, 32'h5A00_0080});
    exp_q.push_back({1'b1, 32'h5A00_0081});
    exp_q.push_back({1'b0, 32'h5A00_0040});
    exp_q.push_back({1'b0, 32'h5A00_0041});
`endif
    fork
      begin
        dbus_access(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, ds);
        #(-1 + 1) dbus_access(1'b1, 1'b0, 32'h0000_0204, 32'h0, 4'h0, ds2);
      end
      begin
        ibus_access(32'h0000_0100, is);
        ibus_access(32'h0000_0104, is2);
      end
    join
    check("b2b_ibus_last", ibus_data_rd, 32'h5A00_0041);
    check("b2b_dbus_last", dbus_data_rd, 32'h5A00_0081);

    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;

    // reset during an access: strobes drop at once, held request restarts
    exp_q.push_back({1'b1, 32'h0});
    fork
      dbus_access(1'b0, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hF, ds);
      begin
        bit seen;
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
          @(negedge clk);
          if (!sram_ce_n) seen = 1;
        end
        check("mid_rst_access_seen", seen, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, sram_be_n},
                 {4'b1110, 4'hF});
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check("mid_rst_state", dbg_state, ST_IDLE);
      end
    join

    repeat (3) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
